seq_divider: RTL and testbench

//  Iterative restoring divider: 32-bit dividend / 4-bit divisor -> 32-bit quotient
//  and 4-bit remainder. It is the inverse of the factorial datapath's count*register

---
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, with a
// go/busy/done handshake. Divide-by-zero completes in one cycle with err set.
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;
  logic [DWIDTH-1:0]   dvs_q, dvs_d;
  logic [DWIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    quot_q, quot_d;
  logic [DWIDTH-1:0]   rem_q, rem_d;
  logic                err_q, err_d;

  logic [DWIDTH:0]     p_shift;
  logic [DWIDTH-1:0]   p_sub;
  logic                q_bit;
  logic [DWIDTH-1:0]   p_next;
  logic [WIDTH-1:0]    dvd_next;

  // The partial remainder never reaches the divisor, so the difference always
  // fits in DWIDTH bits and can be formed modulo 2**DWIDTH.
  always_comb begin
    p_shift  = {p_q, dvd_q[WIDTH-1]};
    q_bit    = (p_shift >= {1'b0, dvs_q});
    p_sub    = p_shift[DWIDTH-1:0] - dvs_q;
    p_next   = q_bit ? p_sub : p_shift[DWIDTH-1:0];
    // Quotient bits enter at the LSB as dividend bits leave at the MSB.
    dvd_next = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (go) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            p_d     = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            err_d   = 1'b0;
            state_d = CALC;
          end else begin
            quot_d  = '0;
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        p_d   = p_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = dvd_next;
          rem_d   = p_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, latency, handshake,
// divide-by-zero, ignored go while busy, and mid-operation reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [31:0] dividend;
  logic [3:0]  divisor;
  logic [31:0] quotient;
  logic [3:0]  remainder;
  logic        busy;
  logic        done;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands with go for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] dvd, input logic [3:0] dvs);
    go       = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [31:0] exp_q, input logic [3:0] exp_r,
                              input logic exp_err);
    check_val({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check_val({tag, "_done"}, {31'b0, done}, 32'd1);
    check_val({tag, "_q"},    quotient, exp_q);
    check_val({tag, "_r"},    {28'b0, remainder}, {28'b0, exp_r});
    check_val({tag, "_err"},  {31'b0, err}, {31'b0, exp_err});
    $display("op %s: q=%0d r=%0d err=%0b lat=%0d", tag, quotient, remainder, err, lat);
  endtask

  // Runs a full isolated operation and confirms done drops the next cycle.
  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [3:0] dvs,
                        input logic [31:0] exp_q, input logic [3:0] exp_r,
                        input logic exp_err, input int exp_lat);
    int lat;
    start_op(dvd, dvs);
    check_val({tag, "_busy0"}, {31'b0, busy}, {31'b0, ~exp_err});
    wait_done(lat);
    check_result(tag, lat, exp_lat, exp_q, exp_r, exp_err);
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  logic [31:0] chain_q [0:8];
  int          lat;
  int          t;
  int          seen_done;

  initial begin
    chain_q = '{32'd362880, 32'd40320, 32'd5040, 32'd720, 32'd120,
                32'd24, 32'd6, 32'd2, 32'd1};
    rst = 1'b1; go = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_q",    quotient, 32'd0);
    check_val("rst_r",    {28'b0, remainder}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_err",  {31'b0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("d120_5",  32'd120, 4'd5, 32'd24, 4'd0, 1'b0, 32);
    run_op("d100_7",  32'd100, 4'd7, 32'd14, 4'd2, 1'b0, 32);
    run_op("dmax_15", 32'hFFFF_FFFF, 4'd15, 32'h1111_1111, 4'd0, 1'b0, 32);
    run_op("dmax_1",  32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFF, 4'd0, 1'b0, 32);
    run_op("d0_9",    32'd0, 4'd9, 32'd0, 4'd0, 1'b0, 32);

    // Back-to-back chain 10!/10/9/.../2 with go held high throughout.
    go = 1'b1; dividend = 32'd3628800; divisor = 4'd10;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      wait_done(lat);
      check_result($sformatf("chain%0d", 10 - k), lat, 32, chain_q[k], 4'd0, 1'b0);
      if (k < 8) begin
        dividend = chain_q[k];
        divisor  = 4'(9 - k);
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_val("chain_end_done", {31'b0, done}, 32'd0);

    run_op("dz55", 32'd55, 4'd0, 32'd0, 4'd0, 1'b1, 0);
    run_op("d9_4", 32'd9, 4'd4, 32'd2, 4'd1, 1'b0, 32);

    // go while busy must be ignored.
    start_op(32'd200, 4'd3);
    t = 0;
    while (!done && t < 100) begin
      if (t == 9) begin
        go = 1'b1; dividend = 32'd50; divisor = 4'd5;
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    go = 1'b0;
    check_result("d200_3", t, 32, 32'd66, 4'd2, 1'b0);
    @(posedge clk); #1;

    // Reset mid-operation: abort silently, then restart immediately.
    start_op(32'd1000, 4'd9);
    seen_done = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_q",    quotient, 32'd0);
    check_val("abort_r",    {28'b0, remainder}, 32'd0);
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_done", {31'b0, done}, 32'd0);
    check_val("abort_err",  {31'b0, err}, 32'd0);
    check_val("abort_nodone", 32'(seen_done), 32'd0);
    run_op("d1000_9", 32'd1000, 4'd9, 32'd111, 4'd1, 1'b0, 32);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
